jtcop_prot_bridge: RTL and testbench

Main-CPU-side bus bridge for the Robocop HuC6280 protection block. It sits between the 68000 address decoder and the 2 kB shared mailbox RAM that the protection CPU also sees. It turns a 68000 bus cycle into a single registered RAM access, inserts wait states and drives DTACK. It also owns the mailbox IRQ to the HuC6280, which is set by a main-CPU write to the last mailbox byte and cleared by the protection side.

---
 rtl/jtcop_prot_bridge.sv | 191 +++++++++++++++++++
 tb/tb_jtcop_prot_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_prot_bridge.sv
// jtcop_prot_bridge: 68000-side bridge into the 2 kB protection mailbox RAM.
// Each 68000 bus cycle becomes one registered RAM access. The bridge adds
// WAIT_CYC wait cycles and then drives DTACK. It also raises the HuC6280
// mailbox IRQ when the 68000 writes the last mailbox byte (0x7FF).
//
// Optional feature: define JTCOP_PROT_IRQ_AUTOCLR_EN to make the IRQ clear
// itself IRQ_HOLD clocks after it was set, even if no ack arrives.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   main_cs/rnw/dsn   68000 select, read/not-write, data strobes (low lane only)
//   main_addr/dout    68000 word address and low write byte
//   main_din          read data {8'hFF, ram byte}
//   main_dtackn       DTACK, active low
//   shd_addr/dout/we  shared RAM address, write data, one-cycle write strobe
//   shd_din           shared RAM read data (one clk read latency)
//   huc_irqn          IRQ1_N to the HuC6280
//   huc_irq_ack       one-cycle ack from the protection side
module jtcop_prot_bridge #(
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned IRQ_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic        main_rnw,
    input  logic [1:0]  main_dsn,
    input  logic [10:0] main_addr,
    input  logic [7:0]  main_dout,
    output logic [15:0] main_din,
    output logic        main_dtackn,
    output logic [10:0] shd_addr,
    output logic [7:0]  shd_dout,
    output logic        shd_we,
    input  logic [7:0]  shd_din,
    output logic        huc_irqn,
    input  logic        huc_irq_ack
);

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned HW = 8;

    localparam logic [AW-1:0] MBOX_ADDR = AW'(11'h7FF);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  wait_cnt;
    logic           rnw_l;
    logic [DW-1:0]  din_lo;
    logic           irq_pend;

    logic           accept_c;
    logic           we_nxt_c;
    logic           cnt_ld_c;
    logic           cnt_dec_c;
    logic           cap_c;
    logic           dtackn_nxt_c;
    logic           irq_set_c;

    // Only the lower byte lane is wired to the RAM.
    logic           dsn_hi_unused;
    assign dsn_hi_unused = main_dsn[1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state; losing main_cs before DONE aborts straight back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (main_cs) state_nxt = S_ACC;
            S_ACC:  state_nxt = main_cs ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!main_cs)              state_nxt = S_IDLE;
                else if (wait_cnt == '0)   state_nxt = S_DONE;
            end
            S_DONE: if (!main_cs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs and datapath strobes
    always_comb begin
        accept_c     = 1'b0;
        we_nxt_c     = 1'b0;
        cnt_ld_c     = 1'b0;
        cnt_dec_c    = 1'b0;
        cap_c        = 1'b0;
        dtackn_nxt_c = 1'b1;
        case (state)
            S_IDLE: begin
                accept_c = main_cs;
                // The strobe register loads on the accept edge, so the write is high during ACC
                we_nxt_c = main_cs & ~main_rnw & ~main_dsn[0];
            end
            S_ACC:  cnt_ld_c = main_cs;
            S_WAIT: begin
                if (main_cs) begin
                    if (wait_cnt == '0) begin
                        cap_c        = rnw_l;
                        dtackn_nxt_c = 1'b0;
                    end else begin
                        cnt_dec_c = 1'b1;
                    end
                end
            end
            S_DONE: dtackn_nxt_c = ~main_cs;
            default: ;
        endcase
    end

    assign irq_set_c = we_nxt_c & (main_addr == MBOX_ADDR);

    // Bus-side datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd_we      <= 1'b0;
            main_dtackn <= 1'b1;
            shd_addr    <= '0;
            shd_dout    <= '0;
            rnw_l       <= 1'b1;
            wait_cnt    <= '0;
            din_lo      <= 8'hFF;
        end else begin
            shd_we      <= we_nxt_c;
            main_dtackn <= dtackn_nxt_c;
            if (accept_c) begin
                shd_addr <= main_addr;
                shd_dout <= main_dout;
                rnw_l    <= main_rnw;
            end
            if (cnt_ld_c)       wait_cnt <= WAIT_LOAD;
            else if (cnt_dec_c) wait_cnt <= wait_cnt - CW'(1);
            if (cap_c)          din_lo   <= shd_din;
        end
    end

    assign main_din = {8'hFF, din_lo};

`ifdef JTCOP_PROT_IRQ_AUTOCLR_EN
    logic [HW-1:0] irq_cnt;

    // Mailbox IRQ: a set (which wins over an ack) reloads the hold timer. The IRQ clears on ack or on timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_pend <= 1'b0;
            irq_cnt  <= '0;
        end else if (irq_set_c) begin
            irq_pend <= 1'b1;
            irq_cnt  <= HW'(IRQ_HOLD);
        end else if (irq_pend) begin
            if (huc_irq_ack || (irq_cnt <= HW'(1))) begin
                irq_pend <= 1'b0;
                irq_cnt  <= '0;
            end else begin
                irq_cnt  <= irq_cnt - HW'(1);
            end
        end
    end
`else
    logic [HW-1:0] irq_hold_unused;
    assign irq_hold_unused = HW'(IRQ_HOLD);

    // Mailbox IRQ: set by the 0x7FF write (set wins), cleared only by the protection-side ack
    always_ff @(posedge clk) begin
        if (!rst_n)          irq_pend <= 1'b0;
        else if (irq_set_c)  irq_pend <= 1'b1;
        else if (huc_irq_ack) irq_pend <= 1'b0;
    end
`endif

    // IRQ output register
    always_ff @(posedge clk) begin
        if (!rst_n) huc_irqn <= 1'b1;
        else        huc_irqn <= ~irq_pend;
    end

endmodule

// File: tb/tb_jtcop_prot_bridge.sv
// Testbench for jtcop_prot_bridge. It runs directed literal checks first, then random 68000 bus
// cycles. A transaction-level model checks every output on every cycle.
module tb_jtcop_prot_bridge;

    localparam int unsigned W    = 1;
    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        main_cs;
    logic        main_rnw;
    logic [1:0]  main_dsn;
    logic [10:0] main_addr;
    logic [7:0]  main_dout;
    logic [15:0] main_din;
    logic        main_dtackn;
    logic [10:0] shd_addr;
    logic [7:0]  shd_dout;
    logic        shd_we;
    logic [7:0]  shd_din;
    logic        huc_irqn;
    logic        huc_irq_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtcop_prot_bridge #(.WAIT_CYC(W), .IRQ_HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_dsn(main_dsn),
        .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din),
        .main_dtackn(main_dtackn),
        .shd_addr(shd_addr), .shd_dout(shd_dout), .shd_we(shd_we), .shd_din(shd_din),
        .huc_irqn(huc_irqn), .huc_irq_ack(huc_irq_ack)
    );

    function automatic logic [7:0] ram_init(int i);
        return 8'(i * 37 + 11);
    endfunction

    // Shared RAM with one clock of read latency
    logic [7:0] ram [0:2047];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) ram[i] <= ram_init(i);
        end else if (shd_we) begin
            ram[shd_addr] <= shd_dout;
        end
        shd_din <= ram[shd_addr];
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mem_m [0:2047];
    bit          m_valid = 0;
    bit          busy;
    int unsigned age;
    bit          m_rnw;
    logic [10:0] m_addr;
    logic [7:0]  m_dout;
    logic [7:0]  m_din;
    bit          m_we;
    bit          m_dtackn;
    bit          m_irqn;
    bit          pend;
`ifdef JTCOP_PROT_IRQ_AUTOCLR_EN
    int unsigned since_set;
`endif

    // A transaction is accepted on the edge that first sees cs. DTACK goes low
    // W+1 edges later if cs is still held. Any cs=0 sample ends the transaction.
    task automatic model_step();
        bit set;
        set = 0;
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) mem_m[i] = ram_init(i);
            busy = 0; age = 0; m_rnw = 1; m_addr = '0; m_dout = '0; m_din = 8'hFF;
            m_we = 0; m_dtackn = 1; m_irqn = 1; pend = 0;
            m_valid = 1;
        end else begin
            m_irqn = ~pend;
            m_we   = 0;
            if (!busy) begin
                m_dtackn = 1;
                if (main_cs) begin
                    busy = 1; age = 0;
                    m_addr = main_addr; m_dout = main_dout; m_rnw = main_rnw;
                    if (!main_rnw && !main_dsn[0]) begin
                        m_we = 1;
                        mem_m[main_addr] = main_dout;
                        if (main_addr == 11'h7FF) set = 1;
                    end
                end
            end else begin
                age++;
                if (!main_cs) begin
                    busy = 0;
                    m_dtackn = 1;
                end else if (age >= 1 + W) begin
                    m_dtackn = 0;
                    if (age == 1 + W && m_rnw) m_din = mem_m[m_addr];
                end
            end
            if (set) begin
                pend = 1;
`ifdef JTCOP_PROT_IRQ_AUTOCLR_EN
                since_set = 0;
`endif
            end else if (pend) begin
                if (huc_irq_ack) pend = 0;
`ifdef JTCOP_PROT_IRQ_AUTOCLR_EN
                since_set++;
                if (since_set >= HOLD) pend = 0;
`endif
            end
        end
    endtask

    // Compare process: check the model at every falling edge
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) begin
                check("dtackn", 16'(main_dtackn), 16'(m_dtackn));
                check("shd_we", 16'(shd_we), 16'(m_we));
                check("shd_addr", 16'(shd_addr), 16'(m_addr));
                check("shd_dout", 16'(shd_dout), 16'(m_dout));
                check("main_din", main_din, {8'hFF, m_din});
                check("huc_irqn", 16'(huc_irqn), 16'(m_irqn));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(logic cs, logic rnw, logic [1:0] dsn, logic [10:0] a, logic [7:0] d);
        main_cs = cs; main_rnw = rnw; main_dsn = dsn; main_addr = a; main_dout = d;
    endtask

    task automatic full_txn(logic rnw, logic [1:0] dsn, logic [10:0] a, logic [7:0] d);
        set_bus(1'b1, rnw, dsn, a, d);
        for (int i = 0; i < int'(W) + 2; i++) step();
        main_cs = 1'b0;
        step();
    endtask

    task automatic rand_txn();
        int h;
        int rst_at;
        logic [10:0] a;
        a = ($urandom_range(0, 4) == 0) ? 11'h7FF : 11'($urandom);
        set_bus(1'b1, 1'($urandom), 2'($urandom), a, 8'($urandom));
        if ($urandom_range(0, 4) == 0) h = $urandom_range(1, W + 1);
        else                           h = W + 2 + $urandom_range(0, 3);
        rst_at = ($urandom_range(0, 24) == 0) ? $urandom_range(0, h - 1) : -1;
        for (int i = 0; i < h; i++) begin
            huc_irq_ack = ($urandom_range(0, 7) == 0);
            if (i == rst_at) begin
                rst_n = 1'b0; main_cs = 1'b0;
                step(); step();
                rst_n = 1'b1;
                break;
            end
            step();
        end
        main_cs = 1'b0;
        for (int g = 0; g < $urandom_range(1, 3); g++) begin
            huc_irq_ack = ($urandom_range(0, 5) == 0);
            step();
        end
        huc_irq_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        huc_irq_ack = 1'b0;
        set_bus(1'b0, 1'b1, 2'b11, 11'h000, 8'h00);
        step(); step();
        check("rst_dtackn", 16'(main_dtackn), 16'h1);
        check("rst_irqn", 16'(huc_irqn), 16'h1);
        check("rst_din", main_din, 16'hFFFF);
        check("rst_we", 16'(shd_we), 16'h0);
        rst_n = 1'b1;
        step();

        // Lower-lane write
        set_bus(1'b1, 1'b0, 2'b10, 11'h012, 8'hA5);
        step();
        check("wr_we_pulse", 16'(shd_we), 16'h1);
        check("wr_addr", 16'(shd_addr), 16'h0012);
        check("wr_dout", 16'(shd_dout), 16'h00A5);
        check("wr_dtackn_early", 16'(main_dtackn), 16'h1);
        step();
        check("wr_we_end", 16'(shd_we), 16'h0);
        step();
        check("wr_dtack", 16'(main_dtackn), 16'h0);
        step();
        check("wr_dtack_hold", 16'(main_dtackn), 16'h0);
        main_cs = 1'b0;
        step();
        check("wr_dtack_release", 16'(main_dtackn), 16'h1);

        // Read back a preloaded byte
        full_txn(1'b0, 2'b10, 11'h012, 8'h3C);
        set_bus(1'b1, 1'b1, 2'b00, 11'h012, 8'h00);
        step();
        check("rd_no_we", 16'(shd_we), 16'h0);
        step(); step();
        check("rd_dtack", 16'(main_dtackn), 16'h0);
        check("rd_data", main_din, 16'hFF3C);
        main_cs = 1'b0;
        step();

`ifdef JTCOP_PROT_IRQ_AUTOCLR_EN
        // IRQ clears itself HOLD cycles after being set
        set_bus(1'b1, 1'b0, 2'b10, 11'h7FF, 8'h11);
        step();
        step();
        check("ac_irq_set", 16'(huc_irqn), 16'h0);
        step();
        main_cs = 1'b0;
        step(); step();
        check("ac_irq_still", 16'(huc_irqn), 16'h0);
        step();
        check("ac_irq_clear", 16'(huc_irqn), 16'h1);
`else
        // IRQ set, held with no ack, then cleared by ack
        set_bus(1'b1, 1'b0, 2'b10, 11'h7FF, 8'h11);
        step();
        check("irq_pre", 16'(huc_irqn), 16'h1);
        step();
        check("irq_set", 16'(huc_irqn), 16'h0);
        step();
        main_cs = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("irq_no_autoclr", 16'(huc_irqn), 16'h0);
        huc_irq_ack = 1'b1;
        step();
        huc_irq_ack = 1'b0;
        check("irq_ack_lag", 16'(huc_irqn), 16'h0);
        step();
        check("irq_ack_clear", 16'(huc_irqn), 16'h1);
        // Ack coincident with a new set: set wins
        full_txn(1'b0, 2'b10, 11'h7FF, 8'h22);
        set_bus(1'b1, 1'b0, 2'b10, 11'h7FF, 8'h33);
        huc_irq_ack = 1'b1;
        step();
        huc_irq_ack = 1'b0;
        step();
        check("irq_set_wins", 16'(huc_irqn), 16'h0);
        step();
        main_cs = 1'b0;
        step(); step();
        check("irq_set_wins_hold", 16'(huc_irqn), 16'h0);
        huc_irq_ack = 1'b1;
        step();
        huc_irq_ack = 1'b0;
        step();
        check("irq_final_clear", 16'(huc_irqn), 16'h1);
`endif

        // Abort in WAIT, then an immediate new read must complete normally
        set_bus(1'b1, 1'b1, 2'b00, 11'h005, 8'h00);
        step(); step();
        main_cs = 1'b0;
        step();
        check("abort_no_dtack", 16'(main_dtackn), 16'h1);
        step();
        check("abort_no_dtack2", 16'(main_dtackn), 16'h1);
        set_bus(1'b1, 1'b1, 2'b00, 11'h006, 8'h00);
        step(); step(); step();
        check("post_abort_dtack", 16'(main_dtackn), 16'h0);
        check("post_abort_data", main_din, {8'hFF, ram_init(6)});
        main_cs = 1'b0;
        step();

        // Upper-lane-only write: no RAM strobe but DTACK still given
        set_bus(1'b1, 1'b0, 2'b01, 11'h020, 8'h77);
        step();
        check("upper_no_we", 16'(shd_we), 16'h0);
        step(); step();
        check("upper_dtack", 16'(main_dtackn), 16'h0);
        main_cs = 1'b0;
        step();

        // Reset in the middle of a bus cycle
        set_bus(1'b1, 1'b0, 2'b10, 11'h030, 8'h99);
        step();
        rst_n = 1'b0; main_cs = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_dtackn", 16'(main_dtackn), 16'h1);
        check("midrst_we", 16'(shd_we), 16'h0);
        step();

        // Random phase, checked by the model
        for (int t = 0; t < 400; t++) rand_txn();

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
